// File: rtl/pacclub_input_pkg.sv
// Shared constants and types for the Pacman Club input-conditioning stage:
// keyboard scan codes, joystick bit positions, coin FSM encoding and the
// direction remap helpers used for the Vert/Horz orientation switch.
package pacclub_input_pkg;

    // Direction keys match on the low 8 bits only (extended prefix ignored).
    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;

    // Start/coin keys require an exact 9-bit match.
    localparam logic [8:0] KEY_START1 = 9'h005;
    localparam logic [8:0] KEY_START2 = 9'h006;
    localparam logic [8:0] KEY_COIN   = 9'h004;

    // Joystick word bit positions (same layout for both players).
    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_COIN   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;

    typedef enum logic [1:0] {
        COIN_IDLE     = 2'd0,
        COIN_HOLD     = 2'd1,
        COIN_WAIT_REL = 2'd2
    } coin_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic start1;
        logic start2;
        logic coin;
    } key_state_t;

    // Extract the four direction bits from the low nibble of a joystick word.
    function automatic dir_t joy_dir(input logic [3:0] joy);
        dir_t d;
        d.up    = joy[JOY_U];
        d.down  = joy[JOY_D];
        d.left  = joy[JOY_L];
        d.right = joy[JOY_R];
        return d;
    endfunction

    // Horz cabinets rotate the controls a quarter turn; Vert passes through.
    function automatic dir_t orient(input dir_t d, input logic rotate);
        dir_t o;
        if (rotate) begin
            o.up    = d.left;
            o.down  = d.right;
            o.left  = d.down;
            o.right = d.up;
        end else begin
            o = d;
        end
        return o;
    endfunction

    // Pack a direction set into the core's {down,right,left,up} bus order.
    function automatic logic [3:0] dir_bus(input dir_t d);
        return {d.down, d.right, d.left, d.up};
    endfunction

endpackage

// File: rtl/pacclub_coin_stretcher.sv
// Coin pulse stretcher: turns any coin request into exactly one pulse that
// lasts until COIN_HOLD_FRAMES vblank rising edges have been seen, then
// waits for the request to drop before it can fire again.
//
// state         | meaning
// --------------+------------------------------------------------------------
// COIN_IDLE     | armed; coin_out follows coin_raw, a request starts a pulse
// COIN_HOLD     | pulse active; counting vblank rising edges
// COIN_WAIT_REL | pulse done; coin_out low until coin_raw is released
module pacclub_coin_stretcher
    import pacclub_input_pkg::*;
#(
    parameter int COIN_HOLD_FRAMES = 3,
    parameter int CNT_W            = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic coin_raw,
    input  logic vblank,
    output logic coin_out
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(COIN_HOLD_FRAMES);

    coin_state_e      state_q;
    coin_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             vblank_q;
    logic             vblank_rise;
    logic             hold_done;

    // vblank history for edge detection; a plain sample so reset never
    // manufactures a spurious edge.
    always_ff @(posedge CLK) begin
        vblank_q <= vblank;
    end

    assign vblank_rise = vblank & ~vblank_q;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign hold_done   = vblank_rise && (cnt_inc == HOLD_LAST);

    // State and frame counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= COIN_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is cleared while idle so a vblank edge
    // coinciding with the trigger cycle is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            COIN_IDLE: begin
                cnt_d = '0;
                if (coin_raw) begin
                    state_d = COIN_HOLD;
                end
            end
            COIN_HOLD: begin
                if (vblank_rise) begin
                    cnt_d = cnt_inc;
                end
                if (hold_done) begin
                    state_d = COIN_WAIT_REL;
                end
            end
            COIN_WAIT_REL: begin
                if (!coin_raw) begin
                    state_d = COIN_IDLE;
                end
            end
            default: begin
                state_d = COIN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode; the pulse starts in the trigger cycle and drops in the
    // cycle the final frame edge is seen.
    always_comb begin
        coin_out = 1'b0;
        case (state_q)
            COIN_IDLE:     coin_out = coin_raw;
            COIN_HOLD:     coin_out = ~hold_done;
            COIN_WAIT_REL: coin_out = 1'b0;
            default:       coin_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/pacclub_input_ctrl.sv
// Input conditioning for the Pacman Club core: tracks held keyboard keys from
// the HPS event word, merges them with both joysticks, applies the Vert/Horz
// remap, stretches the coin pulse and registers the core-facing buses.
module pacclub_input_ctrl
    import pacclub_input_pkg::*;
#(
    parameter int COIN_HOLD_FRAMES = 3,
    parameter int CNT_W            = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    input  logic        vblank,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [3:0]  in_a,
    output logic [3:0]  in_b
);

    logic       toggle_q;
    logic       key_event;
    logic       key_pressed;
    logic [8:0] key_code;
    key_state_t keys_q;

    dir_t       p1_raw;
    dir_t       p1_dir;
    dir_t       p2_dir;
    logic       start1;
    logic       start2;
    logic       coin_raw;
    logic       coin_out;
    logic       unused_joy;

    assign key_event   = ps2_key[10] ^ toggle_q;
    assign key_pressed = ps2_key[9];
    assign key_code    = ps2_key[8:0];

    // Only bits [6:0] of each joystick word are meaningful here.
    assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

    // Held-key tracker: every toggle of the event bit loads the addressed key
    // with its pressed flag; unknown codes leave all keys untouched.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            toggle_q <= ps2_key[10];
            keys_q   <= '0;
        end else begin
            toggle_q <= ps2_key[10];
            if (key_event) begin
                if (key_code[7:0] == KEY_UP)    keys_q.up     <= key_pressed;
                if (key_code[7:0] == KEY_DOWN)  keys_q.down   <= key_pressed;
                if (key_code[7:0] == KEY_LEFT)  keys_q.left   <= key_pressed;
                if (key_code[7:0] == KEY_RIGHT) keys_q.right  <= key_pressed;
                if (key_code == KEY_START1)     keys_q.start1 <= key_pressed;
                if (key_code == KEY_START2)     keys_q.start2 <= key_pressed;
                if (key_code == KEY_COIN)       keys_q.coin   <= key_pressed;
            end
        end
    end

    // Merge sources and apply orientation; rotate acts on the merged set so a
    // mid-press orientation change remaps without touching key state.
    always_comb begin
        p1_raw.up    = keys_q.up;
        p1_raw.down  = keys_q.down;
        p1_raw.left  = keys_q.left;
        p1_raw.right = keys_q.right;
        p1_raw       = p1_raw | joy_dir(joystick_0[3:0]);
        p1_dir       = orient(p1_raw, rotate);
        p2_dir       = orient(joy_dir(joystick_1[3:0]), rotate);
        start1       = keys_q.start1 | joystick_0[JOY_START1] | joystick_1[JOY_START1];
        start2       = keys_q.start2 | joystick_0[JOY_START2] | joystick_1[JOY_START2];
        coin_raw     = keys_q.coin   | joystick_0[JOY_COIN]   | joystick_1[JOY_COIN];
    end

    pacclub_coin_stretcher #(
        .COIN_HOLD_FRAMES (COIN_HOLD_FRAMES),
        .CNT_W            (CNT_W)
    ) u_coin (
        .CLK      (CLK),
        .RESET    (RESET),
        .coin_raw (coin_raw),
        .vblank   (vblank),
        .coin_out (coin_out)
    );

    // Registered core-facing buses: in0/in1 active-low, in_a/in_b active-high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in0  <= 8'hFF;
            in1  <= 8'hFF;
            in_a <= 4'h0;
            in_b <= 4'h0;
        end else begin
            in0  <= ~{5'b0, coin_out, 2'b0};
            in1  <= ~{1'b0, start2, start1, 5'b0};
            in_a <= dir_bus(p1_dir);
            in_b <= dir_bus(p2_dir);
        end
    end

endmodule

// File: tb/tb_pacclub_input_ctrl.sv
// Bench for pacclub_input_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
module tb_pacclub_input_ctrl;

    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] j0;
    logic [15:0] j1;
    logic        rotate;
    logic        vblank;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [3:0]  in_a;
    logic [3:0]  in_b;

    always #5 clk = ~clk;

    pacclub_input_ctrl #(.COIN_HOLD_FRAMES(HOLD), .CNT_W(4)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .ps2_key    (ps2_key),
        .joystick_0 (j0),
        .joystick_1 (j1),
        .rotate     (rotate),
        .vblank     (vblank),
        .in0        (in0),
        .in1        (in1),
        .in_a       (in_a),
        .in_b       (in_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit done = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // kb: 0 up, 1 down, 2 left, 3 right, 4 start1, 5 start2, 6 coin
    bit         kb [7];
    bit         m_tog;
    bit         m_vb;
    bit         m_pulsing;
    bit         m_blocked;
    int         m_frames;
    bit         model_valid = 0;
    logic [7:0] e_in0;
    logic [7:0] e_in1;
    logic [3:0] e_a;
    logic [3:0] e_b;

    // Returns {down,right,left,up} as seen by the core for a given stick.
    function automatic logic [3:0] seen(bit u, bit d, bit l, bit r, bit rot);
        if (!rot) return {d, r, l, u};
        return {r, u, d, l};
    endfunction

    task automatic model_step();
        bit u, d, l, r, s1, s2, raw, rise, coin;
        logic [8:0] code;
        if (reset) begin
            e_in0 = 8'hFF; e_in1 = 8'hFF; e_a = 4'h0; e_b = 4'h0;
            for (int i = 0; i < 7; i++) kb[i] = 0;
            m_tog = ps2_key[10];
            m_pulsing = 0; m_blocked = 0; m_frames = 0;
            model_valid = 1;
        end else begin
            u = kb[0] | j0[3]; d = kb[1] | j0[2]; l = kb[2] | j0[1]; r = kb[3] | j0[0];
            e_a = seen(u, d, l, r, rotate);
            e_b = seen(j1[3], j1[2], j1[1], j1[0], rotate);
            s1  = kb[4] | j0[5] | j1[5];
            s2  = kb[5] | j0[6] | j1[6];
            raw = kb[6] | j0[4] | j1[4];
            e_in1 = 8'hFF;
            if (s1) e_in1[5] = 1'b0;
            if (s2) e_in1[6] = 1'b0;
            rise = vblank && !m_vb;
            if (m_pulsing) begin
                if (rise) m_frames++;
                if (m_frames == HOLD) begin
                    m_pulsing = 0; m_blocked = 1; coin = 0;
                end else coin = 1;
            end else if (m_blocked) begin
                coin = 0;
                if (!raw) m_blocked = 0;
            end else begin
                coin = raw;
                if (raw) begin m_pulsing = 1; m_frames = 0; end
            end
            e_in0 = coin ? 8'hFB : 8'hFF;
            if (ps2_key[10] != m_tog) begin
                code = ps2_key[8:0];
                if (code[7:0] == 8'h75) kb[0] = ps2_key[9];
                if (code[7:0] == 8'h72) kb[1] = ps2_key[9];
                if (code[7:0] == 8'h6B) kb[2] = ps2_key[9];
                if (code[7:0] == 8'h74) kb[3] = ps2_key[9];
                if (code == 9'h005)     kb[4] = ps2_key[9];
                if (code == 9'h006)     kb[5] = ps2_key[9];
                if (code == 9'h004)     kb[6] = ps2_key[9];
            end
            m_tog = ps2_key[10];
        end
        m_vb = vblank;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (model_valid && !done) begin
            chk("model_in0",  in0, e_in0);
            chk("model_in1",  in1, e_in1);
            chk("model_in_a", {4'h0, in_a}, {4'h0, e_a});
            chk("model_in_b", {4'h0, in_b}, {4'h0, e_b});
        end
    end

    // ---------------- stimulus ----------------
    bit         tog = 0;
    logic [8:0] codes [0:11] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B,
                                 9'h074, 9'h174, 9'h005, 9'h006, 9'h004, 9'h104};

    task automatic key(input bit pressed, input logic [8:0] code);
        tog = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    // Three-frame coin pulse tail: FB until the final vblank edge, then FF.
    task automatic frames_check(input string name);
        for (int k = 1; k <= HOLD; k++) begin
            vblank = 1'b1;
            @(negedge clk);
            chk(name, in0, (k < HOLD) ? 8'hFB : 8'hFF);
            vblank = 1'b0;
            @(negedge clk);
            chk(name, in0, (k < HOLD) ? 8'hFB : 8'hFF);
        end
    endtask

    initial begin
        reset = 1'b1; ps2_key = '0; j0 = 16'hFFFF; j1 = 16'hFFFF;
        rotate = 1'b0; vblank = 1'b0;

        repeat (4) begin
            @(negedge clk);
            chk("rst_in0", in0, 8'hFF);
            chk("rst_in1", in1, 8'hFF);
            chk("rst_in_a", {4'h0, in_a}, 8'h00);
            chk("rst_in_b", {4'h0, in_b}, 8'h00);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_a", {4'h0, in_a}, 8'h0F);
        chk("post_rst_in_b", {4'h0, in_b}, 8'h0F);
        chk("post_rst_in1", in1, 8'h9F);
        chk("post_rst_in0", in0, 8'hFB);
        j0 = '0; j1 = '0;
        frames_check("post_rst_coin");
        @(negedge clk);

        key(1'b1, 9'h075);
        @(negedge clk); chk("kbd_up_lat1", {4'h0, in_a}, 8'h00);
        @(negedge clk); chk("kbd_up_press", {4'h0, in_a}, 8'h01);
        key(1'b0, 9'h175);
        @(negedge clk); chk("kbd_up_lat2", {4'h0, in_a}, 8'h01);
        @(negedge clk); chk("kbd_up_release", {4'h0, in_a}, 8'h00);

        rotate = 1'b1; j0 = 16'h0001;
        @(negedge clk); chk("horz_right", {4'h0, in_a}, 8'h08);
        rotate = 1'b0;
        @(negedge clk); chk("vert_right", {4'h0, in_a}, 8'h04);
        j0 = '0;
        @(negedge clk);

        j0 = 16'h0010;
        @(negedge clk); chk("coin_start", in0, 8'hFB);
        j0 = '0;
        @(negedge clk); chk("coin_released_hold", in0, 8'hFB);
        frames_check("coin_stretch");

        j0 = 16'h0010;
        @(negedge clk); chk("coin_held_start", in0, 8'hFB);
        frames_check("coin_held");
        repeat (2) begin
            vblank = 1'b1; @(negedge clk); vblank = 1'b0; @(negedge clk);
            chk("coin_no_retrigger", in0, 8'hFF);
        end
        j0 = '0;
        @(negedge clk); chk("coin_release", in0, 8'hFF);
        j0 = 16'h0010;
        @(negedge clk); chk("coin_repress", in0, 8'hFB);
        j0 = '0;
        frames_check("coin_repress");
        @(negedge clk);

        j0 = 16'h0010;
        @(negedge clk);
        j0 = '0;
        vblank = 1'b1; @(negedge clk); vblank = 1'b0; @(negedge clk);
        chk("mid_coin_hold", in0, 8'hFB);
        reset = 1'b1;
        @(negedge clk); chk("mid_coin_reset", in0, 8'hFF);
        reset = 1'b0;
        @(negedge clk); chk("after_reset_idle", in0, 8'hFF);
        j0 = 16'h0010;
        @(negedge clk); chk("after_reset_press", in0, 8'hFB);
        j0 = '0;
        frames_check("after_reset_full");

        key(1'b1, 9'h006); j1 = 16'h0020;
        @(negedge clk);
        @(negedge clk); chk("starts_merge", in1, 8'h9F);
        key(1'b0, 9'h006); j1 = '0;
        @(negedge clk);
        @(negedge clk); chk("starts_clear", in1, 8'hFF);

        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 5) == 0) key(1'($urandom_range(0, 1)), 9'($urandom));
                else key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)]);
            end
            j0 = 16'($urandom & $urandom & $urandom);
            j1 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) vblank = ~vblank;
            if ($urandom_range(0, 19) == 0) rotate = ~rotate;
            reset = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        @(negedge clk);

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
